hadd_serial_adder_ctrl: RTL and testbench
=========================================

# hadd_serial_adder_ctrl

Bit-serial NBITS-bit adder that time-shares a single half-adder (sum = a ^ b, cout = a & b) across all bit positions and both half-adder steps of each full-add. A controller FSM accepts one operand pair over a val/rdy handshake and walks the bits LSB-first, two cycles per bit. It returns the sum and carry-out over a second val/rdy handshake. It is the area-minimal adder option for slow control-path arithmetic; the half-adder is instantiated inside the block and is its only arithmetic resource.

## Interface
- NBITS, 8, operand and sum width; legal range ≥ 1
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- in_val  input  1  operand pair valid
- in_rdy  output  1  block can accept operands
- in_a  input  NBITS  operand A
- in_b  input  NBITS  operand B
- out_val  output  1  result valid
- out_rdy  input  1  consumer accepts result
- out_sum  output  NBITS  (in_a + in_b) mod 2^NBITS
- out_cout  output  1  carry out of bit NBITS-1

## Operation
- FSM states: IDLE, CALC, DONE. Reset forces IDLE.
- Internal registers:
  - a_q, b_q (latched operands)
  - idx (bit index, width clog2(NBITS), minimum 1)
  - phase (1 bit)
  - s1, c1 (first half-add result)
  - carry
  - sum_q (NBITS)
  - cout_q
- IDLE:
  - in_rdy = 1.
  - On in_val && in_rdy: latch a_q/b_q; clear idx, phase, carry, sum_q, cout_q; go to CALC.
- CALC, phase 0:
  - Half-adder inputs are a_q[idx] and b_q[idx].
  - s1 <= ha.sum, c1 <= ha.cout, phase <= 1.
- CALC, phase 1:
  - Half-adder inputs are s1 and carry.
  - sum_q[idx] <= ha.sum; carry <= c1 | ha.cout; phase <= 0.
  - If idx == NBITS-1: cout_q <= c1 | ha.cout, go to DONE. Otherwise idx <= idx+1.
- DONE:
  - out_val = 1.
  - On out_rdy, go to IDLE next cycle.
- in_rdy = (state == IDLE); out_val = (state == DONE). Both are decoded from registered state only, with no input-to-output combinational path.
- out_sum = sum_q and out_cout = cout_q at all times. They are stable and held throughout DONE.
- in_val outside IDLE is ignored; operands are not sampled.
- in_a/in_b changing after the accept edge has no effect.
- Only one operation in flight at a time; there is no pipelining and no IDLE bypass.

## Timing
- Reset values:
  - state = IDLE
  - sum_q = 0, cout_q = 0, carry = 0, idx = 0, phase = 0, s1 = 0, c1 = 0
- While reset is high:
  - in_rdy = 0 and out_val = 0.
  - out_sum = 0 and out_cout = 0 from the first edge with reset high.
- First cycle after reset deasserts: in_rdy = 1.
- Accept on edge E (IDLE, in_val=1):
  - CALC occupies the 2·NBITS cycles following E.
  - out_val rises 2·NBITS+1 cycles after the cycle in which in_val was sampled. For NBITS=8 this is 17 cycles.
- DONE holds indefinitely while out_rdy = 0.
  - Handshake on edge F (out_val && out_rdy) → IDLE.
  - in_rdy = 1 in the cycle after F.
  - Minimum initiation interval = 2·NBITS+2 cycles (18 for NBITS=8).
- NBITS=1: CALC lasts 2 cycles; idx is constant 0.
- Reset mid-CALC or mid-DONE aborts the operation with no output. The next cycle is IDLE with all registers at reset values.
- Reset coincident with an accept or output handshake: reset wins.
- Wrap-around: the sum is modulo 2^NBITS; the overflow bit appears only on out_cout.

## Test plan
- Basic: NBITS=8, reset 2 cycles, in_a=0x03, in_b=0x05, out_rdy=1 → out_val high 17 cycles after accept with out_sum=0x08, out_cout=0, then in_rdy=1 the next cycle.
- Carry chain and wrap: 0xFF+0x01 → out_sum=0x00, out_cout=1. Then 0xFF+0xFF → out_sum=0xFE, out_cout=1. Then 0x80+0x80 → out_sum=0x00, out_cout=1.
- Backpressure and busy: hold out_rdy=0 for 5 cycles in DONE → out_val stays high and out_sum/out_cout stay constant. Pulse in_val with new operands during CALC and DONE → ignored, result unchanged, in_rdy=0 throughout.
- Back-to-back: in_val held high with 0x12+0x34 then 0x7F+0x01 → results 0x46/0 and 0x80/0. Accepts are exactly 18 cycles apart.
- Reset mid-op: assert reset at CALC cycle 6 of 0xAA+0x55 → no out_val. The next cycle after reset has in_rdy=1 and out_sum=0. A fresh 0x01+0x01 then yields 0x02/0.
- Exhaustive and random: NBITS=1 over all 4 input pairs (latency 3), and 1000 random NBITS=8 pairs with random out_rdy stalls → each result matches (a+b) mod 256 and carry = (a+b)>>8.

Source files
------------

// File: rtl/hadd_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// hadd_serial_adder_ctrl
//
// Bit-serial NBITS-bit adder built around one shared half-adder. A full add
// of bit i is done in two half-add steps:
//   phase 0: (s1, c1)       = HA(a[i], b[i])
//   phase 1: (sum[i], c2)   = HA(s1, carry);  carry <= c1 | c2
// so an operation takes 2*NBITS cycles of CALC, walking the bits LSB-first.
// Operands are taken over an in_val/in_rdy handshake and the result is
// offered over an out_val/out_rdy handshake. One operation at a time.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   in_val    operand pair valid
//   in_rdy    block can accept operands (IDLE)
//   in_a      operand A, NBITS wide
//   in_b      operand B, NBITS wide
//   out_val   result valid (DONE)
//   out_rdy   consumer accepts result
//   out_sum   (in_a + in_b) mod 2^NBITS, held from the last operation
//   out_cout  carry out of bit NBITS-1
// -----------------------------------------------------------------------------

// The only arithmetic resource in the adder.
module hadd_half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b;
  assign cout = a & b;
endmodule

module hadd_serial_adder_ctrl #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_a,
  input  logic [NBITS-1:0] in_b,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_sum,
  output logic             out_cout
);

  // Bit index needs at least one bit even when NBITS == 1.
  localparam int              IDXW     = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [NBITS-1:0] a_q;
  logic [NBITS-1:0] b_q;
  logic [NBITS-1:0] sum_q;
  logic [IDXW-1:0]  idx;
  logic             phase;
  logic             s1;
  logic             c1;
  logic             carry;
  logic             cout_q;

  logic ha_a;
  logic ha_b;
  logic ha_sum;
  logic ha_cout;

  // Operand steering for the shared half-adder: operand bits in phase 0,
  // partial sum and running carry in phase 1.
  assign ha_a = phase ? s1    : a_q[idx];
  assign ha_b = phase ? carry : b_q[idx];

  hadd_half_adder u_ha (
    .a    (ha_a),
    .b    (ha_b),
    .sum  (ha_sum),
    .cout (ha_cout)
  );

  // Handshake flags come from the state register only. They are also held
  // low while reset is asserted: the state register already reads IDLE after
  // the first reset edge, but the block must not advertise readiness until
  // reset is released.
  assign in_rdy   = (state == IDLE) && !reset;
  assign out_val  = (state == DONE) && !reset;
  assign out_sum  = sum_q;
  assign out_cout = cout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every register is assigned with <= so that all updates in this
      // block see the values from before the edge, like real flip-flops.
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      idx    <= '0;
      phase  <= 1'b0;
      s1     <= 1'b0;
      c1     <= 1'b0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_val && in_rdy) begin
            a_q    <= in_a;
            b_q    <= in_b;
            idx    <= '0;
            phase  <= 1'b0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            state  <= CALC;
          end
        end

        CALC: begin
          if (!phase) begin
            s1    <= ha_sum;
            c1    <= ha_cout;
            phase <= 1'b1;
          end else begin
            sum_q[idx] <= ha_sum;
            // At most one of c1 and the second carry can be set, so OR is
            // the full-adder carry.
            carry      <= c1 | ha_cout;
            phase      <= 1'b0;
            if (idx == LAST_IDX) begin
              cout_q <= c1 | ha_cout;
              state  <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        DONE: begin
          if (out_rdy) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hadd_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hadd_serial_adder_ctrl
//
// Drives an NBITS=8 instance with directed and random operations and an
// NBITS=1 instance exhaustively. A transaction-level model (latency counter
// plus plain a+b arithmetic) predicts in_rdy/out_val every cycle and the
// result whenever it is not in the middle of a calculation.
// -----------------------------------------------------------------------------
module tb_hadd_serial_adder_ctrl;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_val;
  logic          in_rdy;
  logic [NB-1:0] in_a;
  logic [NB-1:0] in_b;
  logic          out_val;
  logic          out_rdy;
  logic [NB-1:0] out_sum;
  logic          out_cout;

  logic          in_val1;
  logic          in_rdy1;
  logic [0:0]    in_a1;
  logic [0:0]    in_b1;
  logic          out_val1;
  logic          out_rdy1;
  logic [0:0]    out_sum1;
  logic          out_cout1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  hadd_serial_adder_ctrl #(.NBITS(NB)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_sum  (out_sum),
    .out_cout (out_cout)
  );

  hadd_serial_adder_ctrl #(.NBITS(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val1),
    .in_rdy   (in_rdy1),
    .in_a     (in_a1),
    .in_b     (in_b1),
    .out_val  (out_val1),
    .out_rdy  (out_rdy1),
    .out_sum  (out_sum1),
    .out_cout (out_cout1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model for the NBITS=8 instance. Tracks only what the outside
  // world can see: idle / cycles left in the calculation / result on offer.
  // ---------------------------------------------------------------------------
  bit          m_init = 1'b0;
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [NB:0] m_res  = '0;
  logic [NB-1:0] m_sum = '0;
  logic        m_cout = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_init = 1'b1;
      m_left = 0;
      m_done = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
    end else if (m_init) begin
      if (m_done) begin
        if (out_rdy) m_done = 1'b0;
      end else if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_done = 1'b1;
          {m_cout, m_sum} = m_res;
        end
      end else if (in_val) begin
        m_res  = {1'b0, in_a} + {1'b0, in_b};
        m_left = 2 * NB;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("in_rdy", 32'(in_rdy), 32'(!reset && !m_done && (m_left == 0)));
      check("out_val", 32'(out_val), 32'(!reset && m_done));
      if (m_left == 0) begin
        check("out_sum", 32'(out_sum), 32'(m_sum));
        check("out_cout", 32'(out_cout), 32'(m_cout));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks for the NBITS=8 instance
  // ---------------------------------------------------------------------------

  // Presents an operand pair and returns the cycle in which it was accepted.
  // Returns at 1 time unit after the accept edge.
  task automatic send(input logic [NB-1:0] a, input logic [NB-1:0] b, output int acc);
    bit got;
    got = 1'b0;
    acc = cyc;
    @(negedge clk);
    in_val = 1'b1;
    in_a   = a;
    in_b   = b;
    for (int n = 0; n < 100; n++) begin
      if (in_rdy) begin
        got = 1'b1;
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("accept_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    in_val = 1'b0;
  endtask

  // Waits for the result, holds it for 'stall' extra cycles, optionally pokes
  // in_val with junk operands while busy, then completes the handshake.
  task automatic get_result(input logic [NB-1:0] es, input logic ec, input int stall,
                            input bit poke, input int acc);
    bit got;
    got = 1'b0;
    out_rdy = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_val) begin
        got = 1'b1;
        break;
      end
      if (poke) begin
        check("busy_in_rdy", 32'(in_rdy), 32'd0);
        in_val = 1'($urandom_range(0, 1));
        in_a   = NB'($urandom);
        in_b   = NB'($urandom);
      end
    end
    if (!got) begin
      check("out_val_timeout", 32'd0, 32'd1);
      in_val = 1'b0;
      return;
    end
    check("latency", 32'(cyc - acc), 32'(2 * NB + 1));
    check("result_sum", 32'(out_sum), 32'(es));
    check("result_cout", 32'(out_cout), 32'(ec));
    for (int k = 0; k < stall; k++) begin
      if (poke) begin
        in_val = 1'($urandom_range(0, 1));
        in_a   = NB'($urandom);
        in_b   = NB'($urandom);
      end
      @(negedge clk);
      check("hold_val", 32'(out_val), 32'd1);
      check("hold_sum", 32'(out_sum), 32'(es));
      check("hold_cout", 32'(out_cout), 32'(ec));
      if (poke) check("hold_in_rdy", 32'(in_rdy), 32'd0);
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
    @(negedge clk);
    check("rdy_after_result", 32'(in_rdy), 32'd1);
  endtask

  task automatic op(input logic [NB-1:0] a, input logic [NB-1:0] b,
                    input int stall, input bit poke);
    int acc;
    logic [NB:0] full;
    full = {1'b0, a} + {1'b0, b};
    send(a, b, acc);
    get_result(full[NB-1:0], full[NB], stall, poke, acc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc_t [2];
    int nacc;
    int nres;
    logic [NB-1:0] b2b_sum [2];

    reset    = 1'b1;
    in_val   = 1'b0;
    in_a     = '0;
    in_b     = '0;
    out_rdy  = 1'b0;
    in_val1  = 1'b0;
    in_a1    = '0;
    in_b1    = '0;
    out_rdy1 = 1'b0;

    // Reset for two cycles, then the block must be ready with a cleared result.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_in_rdy", 32'(in_rdy), 32'd1);
    check("post_reset_out_val", 32'(out_val), 32'd0);
    check("post_reset_sum", 32'(out_sum), 32'd0);
    check("post_reset_cout", 32'(out_cout), 32'd0);
    check("post_reset_in_rdy1", 32'(in_rdy1), 32'd1);

    // Basic add and carry / wrap cases with hand-computed results.
    send(8'h03, 8'h05, acc);
    get_result(8'h08, 1'b0, 0, 1'b0, acc);
    send(8'hFF, 8'h01, acc);
    get_result(8'h00, 1'b1, 0, 1'b0, acc);
    send(8'hFF, 8'hFF, acc);
    get_result(8'hFE, 1'b1, 0, 1'b0, acc);
    send(8'h80, 8'h80, acc);
    get_result(8'h00, 1'b1, 0, 1'b0, acc);

    // Backpressure for 5 cycles with junk in_val pulses while busy.
    send(8'h5A, 8'h3C, acc);
    get_result(8'h96, 1'b0, 5, 1'b1, acc);

    // Back-to-back with in_val held high and out_rdy held high.
    b2b_sum[0] = 8'h46;
    b2b_sum[1] = 8'h80;
    nacc = 0;
    nres = 0;
    acc_t[0] = 0;
    acc_t[1] = 0;
    @(negedge clk);
    in_val  = 1'b1;
    in_a    = 8'h12;
    in_b    = 8'h34;
    out_rdy = 1'b1;
    for (int n = 0; n < 120 && nres < 2; n++) begin
      if (out_val) begin
        check("b2b_sum", 32'(out_sum), 32'(b2b_sum[nres]));
        check("b2b_cout", 32'(out_cout), 32'd0);
        nres++;
      end
      if (in_val && in_rdy && nacc < 2) begin
        acc_t[nacc] = cyc;
        nacc++;
      end
      @(posedge clk);
      #1;
      if (nacc == 1) begin
        in_a = 8'h7F;
        in_b = 8'h01;
      end
      if (nacc == 2) in_val = 1'b0;
      @(negedge clk);
    end
    in_val = 1'b0;
    check("b2b_accepts", 32'(nacc), 32'd2);
    check("b2b_results", 32'(nres), 32'd2);
    check("b2b_interval", 32'(acc_t[1] - acc_t[0]), 32'(2 * NB + 2));
    @(posedge clk);
    #1;
    out_rdy = 1'b0;

    // Reset in CALC cycle 6 of 0xAA+0x55 aborts the operation.
    send(8'hAA, 8'h55, acc);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_in_rdy", 32'(in_rdy), 32'd1);
    check("abort_sum", 32'(out_sum), 32'd0);
    check("abort_cout", 32'(out_cout), 32'd0);
    for (int n = 0; n < 20; n++) begin
      check("abort_no_out_val", 32'(out_val), 32'd0);
      @(negedge clk);
    end
    send(8'h01, 8'h01, acc);
    get_result(8'h02, 1'b0, 0, 1'b0, acc);

    // NBITS=1: all four operand pairs, latency 3.
    out_rdy1 = 1'b1;
    for (int p = 0; p < 4; p++) begin
      int  t0;
      int  s;
      bit  got;
      in_a1   = 1'(p >> 1);
      in_b1   = 1'(p);
      s       = (p >> 1) + (p & 1);
      in_val1 = 1'b1;
      got     = 1'b0;
      t0      = cyc;
      for (int n = 0; n < 10; n++) begin
        if (in_rdy1) begin
          got = 1'b1;
          t0  = cyc;
          break;
        end
        @(negedge clk);
      end
      check("n1_accept", 32'(got), 32'd1);
      @(posedge clk);
      #1;
      in_val1 = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        if (out_val1) begin
          got = 1'b1;
          break;
        end
      end
      check("n1_out_val", 32'(got), 32'd1);
      check("n1_latency", 32'(cyc - t0), 32'd3);
      check("n1_sum", 32'(out_sum1), 32'(s & 1));
      check("n1_cout", 32'(out_cout1), 32'(s >> 1));
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    out_rdy1 = 1'b0;

    // Random operands with random stalls and junk in_val pulses.
    for (int i = 0; i < 1000; i++) begin
      op(NB'($urandom), NB'($urandom), int'($urandom_range(0, 3)),
         ($urandom_range(0, 3) == 0));
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
